// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults for the register file and its scoreboard
//
// Purpose : default register width and address width, plus the index of
//           the hard-wired zero register.
// Ports   : none (package)
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-destination bit array with population counter
//
// Purpose : one pending bit per register index. An issue sets the bit of its
//           destination, a write-back clears the bit of its target. Index 0
//           never becomes pending. pend_cnt tracks how many bits are set.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           set_en, set_idx - mark set_idx pending at the edge
//           clr_en, clr_idx - clear the pending bit of clr_idx at the edge
//           look_idx1/2     - lookup indices
//           pend1/2         - pending bit at look_idx1/2 (combinational)
//           pend_cnt        - number of pending indices (registered)
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] look_idx1,
  input  logic [ADDR_W-1:0] look_idx2,
  output logic              pend1,
  output logic              pend2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_REG);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_hit, clr_hit, inc, dec;

  always_comb begin
    pending_d = pending_q;
    set_hit   = set_en && (set_idx != ZERO_IDX);
    clr_hit   = clr_en && (clr_idx != ZERO_IDX);
    // Clear first, then set: an issue and a write-back to the same index in
    // one cycle leave the index pending for the newer instruction.
    if (clr_hit) pending_d[clr_idx] = 1'b0;
    if (set_hit) pending_d[set_idx] = 1'b1;
    // Incremental count: only real 0->1 and 1->0 transitions move it.
    inc   = set_hit && !pending_q[set_idx];
    dec   = clr_hit && pending_q[clr_idx] && !(set_hit && (set_idx == clr_idx));
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pend1    = pending_q[look_idx1];
  assign pend2    = pending_q[look_idx2];
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R1W register file with pending-write scoreboard
//
// Purpose : register file with a hard-wired zero register, optional
//           write-to-read forwarding, and a scoreboard reporting whether a
//           read index still awaits an in-flight write.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           we, waddr, wdata  - write port (also resolves the pending bit)
//           raddr1/2, rdata1/2- combinational read ports
//           issue_en, issue_rd- mark issue_rd as pending
//           busy1/2           - raddr1/2 awaits a write (combinational)
//           pend_cnt          - number of pending registers (registered)
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_hit;
  logic              fwd1, fwd2;
  logic              pend1, pend2;

  assign wr_hit = we && (waddr != ZERO_IDX);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // A write landing this cycle on a read index is forwarded and also hides
  // that index's pending bit, since the value is resolving right now.
  always_comb begin
    fwd1 = (BYPASS != 0) && wr_hit && (waddr == raddr1);
    fwd2 = (BYPASS != 0) && wr_hit && (waddr == raddr2);

    if (raddr1 == ZERO_IDX) rdata1 = '0;
    else if (fwd1)          rdata1 = wdata;
    else                    rdata1 = regs_q[raddr1];

    if (raddr2 == ZERO_IDX) rdata2 = '0;
    else if (fwd2)          rdata2 = wdata;
    else                    rdata2 = regs_q[raddr2];

    busy1 = pend1 && !fwd1;
    busy2 = pend2 && !fwd2;
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_en),
    .set_idx  (issue_rd),
    .clr_en   (we),
    .clr_idx  (waddr),
    .look_idx1(raddr1),
    .look_idx2(raddr2),
    .pend1    (pend1),
    .pend2    (pend2),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        busy1, busy2;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .busy1   (busy1),
    .busy2   (busy2),
    .pend_cnt(pend_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (we && waddr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Check current outputs against the model, clock once, advance the model.
  task automatic cycle();
    #1;
    check("rdata1", 64'(rdata1), 64'(model_read(raddr1)));
    check("rdata2", 64'(rdata2), 64'(model_read(raddr2)));
    check("busy1", 64'(busy1), 64'(model_busy(raddr1)));
    check("busy2", 64'(busy2), 64'(model_busy(raddr2)));
    check("pend_cnt", 64'(pend_cnt), 64'(model_cnt()));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (we && waddr != 5'd0) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (issue_en && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; issue_en = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; issue_en = 1'b0; issue_rd = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset state
    idle(); raddr1 = 5'd1; raddr2 = 5'd31;
    #1;
    check("rst_rdata1", 64'(rdata1), 64'd0);
    check("rst_rdata2", 64'(rdata2), 64'd0);
    check("rst_busy", 64'({busy1, busy2}), 64'd0);
    check("rst_cnt", 64'(pend_cnt), 64'd0);
    cycle();

    // Bypassed write, then stored read
    we = 1'b1; waddr = 5'd1; wdata = 32'hABCDEF01; raddr1 = 5'd1;
    #1 check("bypass_rd", 64'(rdata1), 64'hABCDEF01);
    cycle();
    idle();
    #1 check("stored_rd", 64'(rdata1), 64'hABCDEF01);
    cycle();

    // Zero register ignores writes and issues
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; issue_en = 1'b1; issue_rd = 5'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    cycle();
    idle();
    #1;
    check("x0_rdata", 64'(rdata1), 64'd0);
    check("x0_busy", 64'(busy1), 64'd0);
    check("x0_cnt", 64'(pend_cnt), 64'd0);
    cycle();

    // Issue x5, x6; write-back x5 masks busy and drops the count
    issue_en = 1'b1; issue_rd = 5'd5; raddr1 = 5'd5; raddr2 = 5'd6;
    cycle();
    issue_rd = 5'd6;
    #1;
    check("cnt_after_x5", 64'(pend_cnt), 64'd1);
    check("busy_x5", 64'(busy1), 64'd1);
    cycle();
    idle();
    #1 check("cnt_after_x6", 64'(pend_cnt), 64'd2);
    we = 1'b1; waddr = 5'd5; wdata = 32'h5;
    #1 check("busy_x5_masked", 64'(busy1), 64'd0);
    cycle();
    idle();
    #1;
    check("cnt_after_wb", 64'(pend_cnt), 64'd1);
    check("x5_value", 64'(rdata1), 64'h5);
    cycle();

    // Issue and write x7 together while x7 already pending
    issue_en = 1'b1; issue_rd = 5'd7; raddr2 = 5'd7;
    cycle();
    idle();
    #1 check("cnt_x7_pend", 64'(pend_cnt), 64'd2);
    we = 1'b1; waddr = 5'd7; wdata = 32'h77; issue_en = 1'b1; issue_rd = 5'd7;
    cycle();
    idle();
    #1;
    check("x7_busy", 64'(busy2), 64'd1);
    check("x7_value", 64'(rdata2), 64'h77);
    check("x7_cnt", 64'(pend_cnt), 64'd2);
    cycle();

    // Reset overrides write and issue
    we = 1'b1; waddr = 5'd3; wdata = 32'h33; issue_en = 1'b1; issue_rd = 5'd3;
    cycle();
    idle();
    cycle();
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h99; issue_en = 1'b1; issue_rd = 5'd9;
    cycle();
    idle(); raddr1 = 5'd3; raddr2 = 5'd7;
    #1;
    check("rst_x3", 64'(rdata1), 64'd0);
    check("rst_x7", 64'(rdata2), 64'd0);
    check("rst_busy2", 64'({busy1, busy2}), 64'd0);
    check("rst_cnt2", 64'(pend_cnt), 64'd0);
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      we       = ($urandom_range(0, 1) == 1);
      waddr    = rand_addr();
      wdata    = $urandom;
      issue_en = ($urandom_range(0, 2) != 0);
      issue_rd = rand_addr();
      raddr1   = ($urandom_range(0, 2) == 0) ? waddr : rand_addr();
      raddr2   = ($urandom_range(0, 4) == 0) ? raddr1 : rand_addr();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; NREGS = 2**ADDR_W.
REQ-003 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 we  input  1  write enable for write port.
REQ-007 waddr  input  ADDR_W  write register index.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 raddr1  input  ADDR_W  read port 1 index.
REQ-010 raddr2  input  ADDR_W  read port 2 index.
REQ-011 rdata1  output  DATA_W  read port 1 data, combinational.
REQ-012 rdata2  output  DATA_W  read port 2 data, combinational.
REQ-013 issue_en  input  1  marks issue_rd as pending (destination of an in-flight instruction).
REQ-014 issue_rd  input  ADDR_W  register index to mark pending.
REQ-015 busy1  output  1  raddr1 has an outstanding pending write, combinational.
REQ-016 busy2  output  1  raddr2 has an outstanding pending write, combinational.
REQ-017 pend_cnt  output  ADDR_W+1  number of registers currently pending, registered.

Function
REQ-018 Register 0 SHALL read as 0 always; writes to index 0 and issues to index 0 SHALL be ignored; busy for index 0 SHALL be 0.
REQ-019 When we=1 and waddr!=0, regs[waddr] SHALL take wdata at the rising edge; write latency 1 cycle.
REQ-020 rdataN SHALL equal regs[raddrN] combinationally; if BYPASS=1 and we=1 and waddr==raddrN!=0, rdataN SHALL equal wdata in the same cycle.
REQ-021 Both read ports SHALL be independent; raddr1==raddr2 SHALL return identical data.
REQ-022 Pending bit of issue_rd SHALL set at the edge when issue_en=1 and issue_rd!=0.
REQ-023 Pending bit of waddr SHALL clear at the edge when we=1 and waddr!=0.
REQ-024 Simultaneous issue and write to the same index: pending SHALL remain set (new issue wins); data write still occurs.
REQ-025 Issue to an already-pending register SHALL leave it pending; write to a non-pending register SHALL be accepted and leave it clear.
REQ-026 busyN SHALL be pending[raddrN], masked to 0 when BYPASS=1 and we=1 and waddr==raddrN (write resolving this cycle).
REQ-027 pend_cnt SHALL equal popcount of pending bits after each edge: +1, -1, or unchanged per REQ-022..025; never exceeds NREGS-1.

Reset
REQ-028 On rst=1 at a rising edge, all registers SHALL become 0, all pending bits 0, pend_cnt 0.
REQ-029 rst SHALL override we and issue_en in the same cycle; reset mid-operation discards in-flight pending state.
REQ-030 After reset all rdataN=0, busyN=0 until the first write/issue edge.

Structure
REQ-031 Shared package rf_pkg SHALL hold DATA_W/ADDR_W defaults and the zero-register index constant.
REQ-032 Pending-bit array and counter SHALL be a sub-module rf_scoreboard (ports clk, rst, set/clear indices and enables, two lookup indices, pend_cnt).

Verification
REQ-033 rst 1 cycle, then read x1,x31 -> rdata1=rdata2=0, busy=0, pend_cnt=0.
REQ-034 we=1 waddr=1 wdata=32'hABCDEF01, raddr1=1 same cycle -> rdata1=32'hABCDEF01 (bypass); next cycle with we=0 -> still 32'hABCDEF01.
REQ-035 write waddr=0 wdata=32'hFFFFFFFF, issue_rd=0 -> rdata for x0=0, busy=0, pend_cnt=0.
REQ-036 issue x5, x6 on successive cycles -> pend_cnt 1 then 2, busy1 for x5=1; write x5=32'h5 -> busy for x5 masked same cycle, pend_cnt=1 after edge.
REQ-037 issue_rd=7 and waddr=7 same cycle -> x7 pending stays 1, regs[7]=wdata, pend_cnt unchanged.
REQ-038 With x3=32'h33 written and x3 pending, assert rst together with we -> all regs 0, pend_cnt=0, busy=0 next cycle.
